cdc_handshake_tx: RTL and testbench
===================================

# cdc_handshake_tx

Four-phase req/ack transmitter: drives a parallel word plus `req_out` from the FPGA clock domain to an asynchronous peer (MCU or another clock domain) and completes the transfer when the peer's `ack_in`, synchronized internally, rises and then falls. It sends data in the direction opposite to our input synchronizers. It sits between FPGA producer logic, which uses a valid/ready interface, and the off-domain receiver.

## Interface
- `WIDTH`, 8: data word width.
- `SYNC_STAGES`, 2: flop stages on `ack_in`; legal range 2..4.
- `TIMEOUT_CYCLES`, 1024: abort threshold, used only with `CDC_HS_TIMEOUT_EN`; must be ≥ 4.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-low; sampled on `clk` posedge.
- `send_valid` in 1: producer has a word.
- `send_data` in WIDTH: word, sampled only on accept.
- `send_ready` out 1: block can accept; combinational from registered state.
- `data_out` out WIDTH: registered word to peer.
- `req_out` out 1: registered request to peer.
- `ack_in` in 1: asynchronous acknowledge from peer.
- `done` out 1: one-cycle pulse on handshake completion.
- `err` out 1: one-cycle pulse on timeout abort; constant 0 without `CDC_HS_TIMEOUT_EN`.

## Operation
- `ack_in` passes through a `SYNC_STAGES`-deep flop chain; the FSM uses only the last stage, `ack_s`.
- FSM states and transitions:
  - IDLE → SETUP on accept.
  - SETUP → REQ unconditionally.
  - REQ → RELEASE when `ack_s`=1.
  - RELEASE → IDLE when `ack_s`=0.
- `send_ready` = (state==IDLE) && !`ack_s`. Accept = `send_valid` && `send_ready`.
- On accept, `data_out` ← `send_data`. `data_out` holds its value until the next accept and is never altered mid-transfer. `send_data` changes outside accept are ignored.
- SETUP provides one cycle of data-before-req setup.
- `req_out` is 1 exactly while in REQ; it is registered alongside the state.
- `done` pulses for one cycle on the RELEASE→IDLE transition.
- If `ack_s`=1 while in IDLE (peer protocol violation or late ack), `send_ready` stays 0 until `ack_s` returns to 0. No error is flagged.
- Only one transfer is in flight at a time; there is no buffering.

## Timing
- Reset values, applied at the first posedge with `reset`=0:
  - state IDLE, `req_out` 0, `data_out` 0, `done` 0, `err` 0.
  - All sync flops 0.
  - Therefore `send_ready`=1 after reset.
- Reset mid-handshake: outputs return to their reset values at the next edge, which drops `req_out` regardless of `ack_in`. The peer must tolerate this.
- Accept at edge E:
  - `data_out` valid after E.
  - `req_out`=1 after E+1.
- Zero-delay peer with `SYNC_STAGES`=2:
  - `ack_s` rises after E+3.
  - FSM enters RELEASE at E+4 and `req_out`=0.
  - `ack_s` falls after E+6.
  - FSM enters IDLE at E+7; `done`=1 during the cycle after E+7.
  - Next accept is possible at E+8.
- Minimum transfer period is 2·`SYNC_STAGES`+4 cycles.
- `send_valid` held high continuously yields back-to-back transfers at that period.

## Configuration
- Macro: `CDC_HS_TIMEOUT_EN`.
- When defined:
  - A cycle counter resets on entry to REQ and runs through REQ and RELEASE.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, `req_out` becomes 0, and `err` pulses for one cycle. `done` does not pulse.
  - The counter is cleared on any return to IDLE.
- When undefined:
  - No counter logic is built and `err` is tied to 0.
  - The FSM waits indefinitely in REQ or RELEASE.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `ack_in`=1 → `req_out`=0, `data_out`=0x00, `done`=0. Then release with `ack_in`=0 → `send_ready`=1 after 2 edges.
- Single transfer: send 0xA5 with a zero-delay peer → `data_out`=0xA5 after E, `req_out` high after E+1 and low at E+4, `done` pulse after E+7.
- Slow peer: ack rises 10 cycles after req and falls 7 cycles after req drops → `req_out` held until `ack_s`, `data_out` stable at 0x3C throughout, exactly one `done`.
- Back-to-back: `send_valid` high continuously with data 0x01,0x02,0x03 → three transfers 8 cycles apart, each `data_out` changes only on accept, 3 `done` pulses.
- Stuck ack: `ack_in`=1 while idle → `send_ready`=0, no accept. Drop `ack_in` → `send_ready`=1 after 2 edges.
- With `CDC_HS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, peer never acks → `req_out` high for 16 cycles, then drops, `err` pulses once, no `done`, `send_ready`=1. Without the macro, `req_out` stays high for 100+ cycles and `err`=0.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Brief    : Four-phase req/ack word transmitter towards an asynchronous peer.
//            Optional timeout abort is built when CDC_HS_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             send_valid,
    input  logic [WIDTH-1:0] send_data,
    output logic             send_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             req_out,
    input  logic             ack_in,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_REQ     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic [WIDTH-1:0]       r_data;
    logic                   r_req;
    logic                   r_done;
    logic                   w_ack_s;
    logic                   w_accept;
    logic                   w_done_next;
    logic                   w_timeout;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 4) begin : g_bad_params
            $error("cdc_handshake_tx: illegal parameter value");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign w_ack_s    = r_ack_sync[SYNC_STAGES-1];
    // A late or stuck ack blocks new transfers until the peer lets go.
    assign send_ready = (r_state == S_IDLE) && !w_ack_s;
    assign w_accept   = send_valid && send_ready;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    // Counter is zero in SETUP, so it restarts on every entry to REQ.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ || r_state == S_RELEASE) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_timeout = (r_state == S_REQ || r_state == S_RELEASE) &&
                       (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_next = S_SETUP;
            S_SETUP:   w_state_next = S_REQ;
            S_REQ:     if (w_ack_s) w_state_next = S_RELEASE;
            S_RELEASE: begin
                if (!w_ack_s) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next == S_REQ);
            r_done  <= w_done_next;
            if (w_accept) begin
                r_data <= send_data;
            end
        end
    end

    assign data_out = r_data;
    assign req_out  = r_req;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Brief    : Scoreboard-based bench for cdc_handshake_tx with a modelled peer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

    localparam int WIDTH          = 8;
    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int PERIOD         = 2 * SYNC_STAGES + 4;

    logic             clk;
    logic             reset;
    logic             send_valid;
    logic [WIDTH-1:0] send_data;
    logic             send_ready;
    logic [WIDTH-1:0] data_out;
    logic             req_out;
    logic             ack_in;
    logic             done;
    logic             err;

    logic             peer_fast;
    logic             ack_man;
    int               checks   = 0;
    int               errors   = 0;
    int               done_cnt = 0;
    int               err_cnt  = 0;
    logic [WIDTH-1:0] exp_q[$];

    // Zero-delay peer mirrors req; otherwise the test drives ack directly.
    assign ack_in = peer_fast ? req_out : ack_man;

    cdc_handshake_tx #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .send_valid (send_valid),
        .send_data  (send_data),
        .send_ready (send_ready),
        .data_out   (data_out),
        .req_out    (req_out),
        .ack_in     (ack_in),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ack_man = 1'b1; peer_fast = 1'b0;
        send_valid = 1'b0; send_data = '0;
        repeat (3) step();
        checks++; if (req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        ack_man = 1'b0; reset = 1'b1;
        repeat (2) step();
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", send_ready); end
    endtask

    task automatic test_single_transfer();
        logic [WIDTH-1:0] got;
        logic             exp_req;
        logic             exp_done;
        peer_fast = 1'b1;
        send_data = 8'hA5; send_valid = 1'b1;
        exp_q.push_back(8'hA5);
        step();
        send_valid = 1'b0; send_data = 8'h00;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            exp_req  = (k >= 1 && k <= 3);
            exp_done = (k == 7);
            checks++; if (req_out !== exp_req) begin errors++; $display("FAIL single_req E+%0d: got %b want %b", k, req_out, exp_req); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL single_done E+%0d: got %b want %b", k, done, exp_done); end
            checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL single_data E+%0d: got %h want a5", k, data_out); end
            if (done === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL single_sb: done with empty queue"); end
                else begin
                    got = exp_q.pop_front();
                    if (data_out !== got) begin errors++; $display("FAIL single_sb: got %h want %h", data_out, got); end
                end
            end
        end
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL single_ready E+8: got %b want 1", send_ready); end
    endtask

    task automatic test_slow_peer();
        logic [WIDTH-1:0] got;
        int               d0;
        bit               seen;
        peer_fast = 1'b0; ack_man = 1'b0;
        d0 = done_cnt;
        send_data = 8'h3C; send_valid = 1'b1;
        exp_q.push_back(8'h3C);
        step();
        send_valid = 1'b0; send_data = 8'hFF;
        step();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (req_out !== 1'b1 || data_out !== 8'h3C) begin
                errors++; $display("FAIL slow_hold %0d: req %b data %h want req 1 data 3c", k, req_out, data_out);
            end
            step();
        end
        ack_man = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (req_out !== (k < 3)) begin errors++; $display("FAIL slow_req_drop %0d: got %b want %b", k, req_out, (k < 3)); end
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (req_out !== 1'b0 || data_out !== 8'h3C || done !== 1'b0) begin
                errors++; $display("FAIL slow_release %0d: req %b data %h done %b want 0 3c 0", k, req_out, data_out, done);
            end
            step();
        end
        ack_man = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL slow_sb: done with empty queue"); end
                else begin
                    got = exp_q.pop_front();
                    if (data_out !== got) begin errors++; $display("FAIL slow_sb: got %h want %h", data_out, got); end
                end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL slow_done_timeout: no done within 10 cycles"); end
        repeat (2) step();
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL slow_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [3];
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] got;
        int               idx;
        int               last;
        int               dones;
        bit               acc;
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03;
        peer_fast = 1'b1;
        idx = 0; last = 0; dones = 0;
        prev = data_out;
        send_data = vals[0]; send_valid = 1'b1;
        for (int cyc = 1; cyc <= 60 && dones < 3; cyc++) begin
            acc = send_valid && send_ready;
            if (acc) exp_q.push_back(send_data);
            step();
            if (acc) begin
                checks++; if (data_out !== vals[idx]) begin errors++; $display("FAIL b2b_data %0d: got %h want %h", idx, data_out, vals[idx]); end
                if (idx > 0) begin
                    checks++; if (cyc - last != PERIOD) begin errors++; $display("FAIL b2b_period %0d: got %0d want %0d", idx, cyc - last, PERIOD); end
                end
                last = cyc;
                idx++;
                if (idx < 3) send_data = vals[idx];
                else begin send_valid = 1'b0; send_data = 8'h00; end
            end else begin
                checks++; if (data_out !== prev) begin errors++; $display("FAIL b2b_stable cyc %0d: got %h want %h", cyc, data_out, prev); end
            end
            prev = data_out;
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb: done with empty queue"); end
                else begin
                    got = exp_q.pop_front();
                    if (data_out !== got) begin errors++; $display("FAIL b2b_sb: got %h want %h", data_out, got); end
                end
            end
        end
        send_valid = 1'b0;
        checks++; if (idx != 3) begin errors++; $display("FAIL b2b_accepts: got %0d want 3", idx); end
        checks++; if (dones != 3) begin errors++; $display("FAIL b2b_dones: got %0d want 3", dones); end
    endtask

    task automatic test_stuck_ack();
        logic [WIDTH-1:0] held;
        held = data_out;
        peer_fast = 1'b0; ack_man = 1'b1;
        repeat (3) step();
        checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL stuck_ready: got %b want 0", send_ready); end
        send_valid = 1'b1; send_data = 8'h77;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (send_ready !== 1'b0 || req_out !== 1'b0 || data_out !== held) begin
                errors++; $display("FAIL stuck_no_accept %0d: ready %b req %b data %h want 0 0 %h", k, send_ready, req_out, data_out, held);
            end
        end
        send_valid = 1'b0;
        ack_man = 1'b0;
        step();
        checks++; if (send_ready !== 1'b0) begin errors++; $display("FAIL stuck_ready_1edge: got %b want 0", send_ready); end
        step();
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL stuck_ready_2edge: got %b want 1", send_ready); end
    endtask

    task automatic test_reset_mid();
        peer_fast = 1'b0; ack_man = 1'b0;
        send_data = 8'h99; send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        repeat (2) step();
        checks++; if (req_out !== 1'b1) begin errors++; $display("FAIL midrst_pre_req: got %b want 1", req_out); end
        ack_man = 1'b1;
        reset = 1'b0;
        step();
        checks++;
        if (req_out !== 1'b0 || data_out !== 8'h00 || done !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: req %b data %h done %b want 0 00 0", req_out, data_out, done);
        end
        ack_man = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", send_ready); end
    endtask

    task automatic test_timeout();
        int n_hi;
        int d0;
        int e0;
        peer_fast = 1'b0; ack_man = 1'b0;
        d0 = done_cnt; e0 = err_cnt; n_hi = 0;
        send_data = 8'h5A; send_valid = 1'b1;
        step();
        send_valid = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
        for (int k = 0; k < 40; k++) begin
            step();
            if (req_out === 1'b1) n_hi++;
        end
        checks++; if (n_hi != TIMEOUT_CYCLES) begin errors++; $display("FAIL timeout_req_cycles: got %0d want %0d", n_hi, TIMEOUT_CYCLES); end
        checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL timeout_err_pulses: got %0d want 1", err_cnt - e0); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL timeout_no_done: got %0d want 0", done_cnt - d0); end
        checks++; if (send_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b want 1", send_ready); end
`else
        for (int k = 0; k < 120; k++) begin
            step();
            if (req_out === 1'b1) n_hi++;
        end
        checks++; if (n_hi != 120) begin errors++; $display("FAIL noto_req_held: got %0d want 120", n_hi); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL noto_err: got %0d pulses want 0", err_cnt - e0); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL noto_no_done: got %0d want 0", done_cnt - d0); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_transfer();
        repeat (2) step();
        test_slow_peer();
        repeat (2) step();
        test_back_to_back();
        repeat (2) step();
        test_stuck_ack();
        test_reset_mid();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
